inv_sub_bytes_seq: RTL and testbench

- Iterative AES InvSubBytes engine, the decrypt-side counterpart of the combinational forward SubBytes stage.
- Applies the inverse AES S-box to all 16 bytes of a 128-bit state, BYTES_PER_CYCLE bytes per clock, through a small shared inverse S-box bank.
- Uses valid/ready handshakes on both sides.
- Sits in the decryption round datapath between InvShiftRows and AddRoundKey.

---
 rtl/inv_sub_bytes_seq.sv | 203 ++++++++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_seq
//
// Iterative AES InvSubBytes engine. A 128-bit state is accepted into a working
// register and its 16 bytes are replaced by their inverse S-box values,
// BYTES_PER_CYCLE bytes per clock, through a bank of BYTES_PER_CYCLE shared
// lookup slots. Sits between InvShiftRows and AddRoundKey in the decrypt round.
//
// Optional build macro: INV_SUB_BYTES_FWD_EN
//   Adds the 'fwd' input. fwd is captured with the block; when set, the forward
//   S-box is applied instead, so the same engine can serve the encrypt path.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_state is valid
//   in_ready   engine idle, can accept a state (IDLE only)
//   in_state   input state, byte i = in_state[8i+7:8i]
//   fwd        (INV_SUB_BYTES_FWD_EN only) use forward S-box for this block
//   out_valid  out_state holds a complete result (DONE only)
//   out_ready  downstream accepts the result
//   out_state  working/result register, byte i = InvSbox(input byte i)
//   busy       high in RUN or DONE
// -----------------------------------------------------------------------------
module inv_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
`ifdef INV_SUB_BYTES_FWD_EN
    input  logic         fwd,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int BPC_SAFE = (BYTES_PER_CYCLE > 0) ? BYTES_PER_CYCLE : 1;
    localparam int N        = 16 / BPC_SAFE;
    localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam int CHUNK_W  = 8 * BPC_SAFE;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bpc_check
        $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // Row r of the table is the 128-bit literal r; entry 0 is the leftmost byte.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

`ifdef INV_SUB_BYTES_FWD_EN
    localparam logic [0:255][7:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        return FWD_SBOX[b];
    endfunction

    logic fwd_q;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CHUNK_W-1:0] chunks [N];
    logic [CHUNK_W-1:0] chunk_in;
    logic [CHUNK_W-1:0] chunk_out;
    logic [127:0]       sub_state;

    // Split the working register into N chunks; the selected chunk goes
    // through the S-box slots and is written back, the rest pass unchanged.
    for (genvar c = 0; c < N; c++) begin : g_chunk
        assign chunks[c] = out_state[c*CHUNK_W +: CHUNK_W];
        assign sub_state[c*CHUNK_W +: CHUNK_W] =
            (cnt == CNT_W'(c)) ? chunk_out : chunks[c];
    end

    if (N == 1) begin : g_sel_single
        assign chunk_in = chunks[0];
    end else begin : g_sel_multi
        assign chunk_in = chunks[cnt];
    end

    for (genvar k = 0; k < BPC_SAFE; k++) begin : g_slot
`ifdef INV_SUB_BYTES_FWD_EN
        assign chunk_out[8*k +: 8] = fwd_q ? fwd_sbox(chunk_in[8*k +: 8])
                                           : inv_sbox(chunk_in[8*k +: 8]);
`else
        assign chunk_out[8*k +: 8] = inv_sbox(chunk_in[8*k +: 8]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == LAST_CNT) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // Handoff returns to IDLE; the next accept is a cycle later.
                if (out_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                busy      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            out_state <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
            fwd_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_state <= in_state;
                        cnt       <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
                        fwd_q     <= fwd;
`endif
                    end
                end
                RUN: begin
                    out_state <= sub_state;
                    cnt       <= (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
`timescale 1ns/1ps
module tb_inv_sub_bytes_seq;

    localparam int NDUT = 5;
    localparam logic [127:0] V1 = 128'h637C777BF26B6FC53001672BFED7AB76;
    localparam logic [127:0] E1 = 128'h000102030405060708090A0B0C0D0E0F;

    function automatic int bpc_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            3:       return 8;
            default: return 16;
        endcase
    endfunction

    logic              clk = 1'b0;
    logic              rst_n;
    logic              out_ready;
    logic [127:0]      in_state;
    logic [NDUT-1:0]   in_valid_a;
    logic [NDUT-1:0]   in_ready_a;
    logic [NDUT-1:0]   out_valid_a;
    logic [NDUT-1:0]   busy_a;
    logic [127:0]      out_state_a [NDUT];
`ifdef INV_SUB_BYTES_FWD_EN
    logic              fwd;
`endif

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_q [NDUT][$];
    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        inv_sub_bytes_seq #(.BYTES_PER_CYCLE(bpc_of(g))) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_state  (in_state),
`ifdef INV_SUB_BYTES_FWD_EN
            .fwd       (fwd),
`endif
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready),
            .out_state (out_state_a[g]),
            .busy      (busy_a[g])
        );
    end

    // Reference S-boxes built from GF(2^8) inversion plus the AES affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] w;
        w = {v, v} << n;
        return w[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0] y;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            y = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
            s = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_inv(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present one block to instance g and record its expected result.
    // Returns at the falling edge just after the accept edge.
    task automatic drive_accept(input int g, input logic [127:0] d, input logic [127:0] e);
        @(negedge clk);
        in_state = d;
        in_valid_a[3'(g)] = 1'b1;
        exp_q[3'(g)].push_back(e);
        @(negedge clk);
        in_valid_a[3'(g)] = 1'b0;
        in_state = ~d;
    endtask

    // Cycles after the accept edge until out_valid is seen; -1 on timeout.
    task automatic wait_out(input int g, output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (out_valid_a[3'(g)]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        in_valid_a = '0;
        out_ready  = 1'b1;
        in_state   = '0;
`ifdef INV_SUB_BYTES_FWD_EN
        fwd        = 1'b0;
`endif
        repeat (2) @(negedge clk);
        total++; if (in_ready_a[0] !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready_a[0]); end
        total++; if (out_valid_a[0] !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid_a[0]); end
        total++; if (busy_a[0] !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a[0]); end
        total++; if (out_state_a[0] !== 128'h0) begin bad++; $display("FAIL reset_out_state: got %h want 0", out_state_a[0]); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        logic [127:0] e;
        out_ready = 1'b1;
        drive_accept(0, V1, E1);
        total++; if (busy_a[0] !== 1'b1 || in_ready_a[0] !== 1'b0)
            begin bad++; $display("FAIL basic_run_flags: busy=%b in_ready=%b want busy=1 in_ready=0", busy_a[0], in_ready_a[0]); end
        wait_out(0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
        total++;
        if (exp_q[0].size() == 0) begin bad++; $display("FAIL basic_data: no expected entry"); end
        else begin
            e = exp_q[0].pop_front();
            if (out_state_a[0] !== e) begin bad++; $display("FAIL basic_data: got %h want %h", out_state_a[0], e); end
        end
        total++; if (in_ready_a[0] !== 1'b0) begin bad++; $display("FAIL basic_done_in_ready: got %b want 0", in_ready_a[0]); end
        @(negedge clk);
        total++; if (in_ready_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0)
            begin bad++; $display("FAIL basic_handoff: in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready_a[0], out_valid_a[0], busy_a[0]); end
    endtask

    // Zeros, ones, every byte value once, and a few random states, back to back.
    task automatic test_patterns();
        int lat;
        logic [127:0] d;
        logic [127:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i == 0) begin
                d = '0; e = {16{8'h52}};
            end else if (i == 1) begin
                d = '1; e = {16{8'h7D}};
            end else if (i < 18) begin
                for (int b = 0; b < 16; b++) d[8*b +: 8] = 8'((i - 2) * 16 + b);
                e = model_inv(d);
            end else begin
                d = rnd128(); e = model_inv(d);
            end
            drive_accept(0, d, e);
            wait_out(0, lat);
            total++; if (lat !== 4) begin bad++; $display("FAIL pat%0d_latency: got %0d want 4", i, lat); end
            total++;
            if (exp_q[0].size() == 0) begin bad++; $display("FAIL pat%0d_data: no expected entry", i); end
            else begin
                e = exp_q[0].pop_front();
                if (out_state_a[0] !== e) begin bad++; $display("FAIL pat%0d_data: got %h want %h", i, out_state_a[0], e); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] d;
        logic [127:0] e;
        d = rnd128();
        out_ready = 1'b0;
        drive_accept(0, d, model_inv(d));
        wait_out(0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL bp_latency: got %0d want 4", lat); end
        e = '0;
        total++;
        if (exp_q[0].size() == 0) begin bad++; $display("FAIL bp_data: no expected entry"); end
        else e = exp_q[0].pop_front();
        for (int c = 0; c < 10; c++) begin
            if (out_state_a[0] !== e || out_valid_a[0] !== 1'b1 || in_ready_a[0] !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: out_state=%h out_valid=%b in_ready=%b want %h 1 0",
                         c, out_state_a[0], out_valid_a[0], in_ready_a[0], e);
            end
            if (c == 3) begin in_valid_a[0] = 1'b1; in_state = ~d; end
            if (c == 4) in_valid_a[0] = 1'b0;
            @(negedge clk);
            if (c < 9) total++;
        end
        total++; if (out_state_a[0] !== e) begin bad++; $display("FAIL bp_final_data: got %h want %h", out_state_a[0], e); end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1)
            begin bad++; $display("FAIL bp_handoff: out_valid=%b in_ready=%b want 0 1", out_valid_a[0], in_ready_a[0]); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++; if (busy_a[0] !== 1'b0 || out_valid_a[0] !== 1'b0)
                begin bad++; $display("FAIL bp_no_phantom%0d: busy=%b out_valid=%b want 0 0", c, busy_a[0], out_valid_a[0]); end
        end
    endtask

    task automatic test_sweep();
        int lat [NDUT];
        logic [127:0] e;
        out_ready = 1'b1;
        @(negedge clk);
        in_state   = V1;
        in_valid_a = '1;
        for (int g = 0; g < NDUT; g++) exp_q[3'(g)].push_back(E1);
        @(negedge clk);
        in_valid_a = '0;
        in_state   = '0;
        for (int g = 0; g < NDUT; g++) lat[g] = -1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                if (lat[g] < 0 && out_valid_a[3'(g)]) begin
                    lat[g] = c;
                    total++;
                    if (exp_q[3'(g)].size() == 0) begin bad++; $display("FAIL sweep_bpc%0d_data: no expected entry", bpc_of(g)); end
                    else begin
                        e = exp_q[3'(g)].pop_front();
                        if (out_state_a[3'(g)] !== e)
                            begin bad++; $display("FAIL sweep_bpc%0d_data: got %h want %h", bpc_of(g), out_state_a[3'(g)], e); end
                    end
                end
            end
        end
        for (int g = 0; g < NDUT; g++) begin
            total++; if (lat[g] !== 16 / bpc_of(g))
                begin bad++; $display("FAIL sweep_bpc%0d_latency: got %0d want %0d", bpc_of(g), lat[g], 16 / bpc_of(g)); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [127:0] d;
        logic [127:0] e;
        out_ready = 1'b1;
        drive_accept(0, V1, E1);
        @(negedge clk);
        total++; if (busy_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0)
            begin bad++; $display("FAIL rstmid_pre: busy=%b out_valid=%b want 1 0", busy_a[0], out_valid_a[0]); end
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++) exp_q[3'(g)].delete();
        total++; if (out_valid_a[0] !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid_a[0]); end
        total++; if (out_state_a[0] !== 128'h0) begin bad++; $display("FAIL rstmid_out_state: got %h want 0", out_state_a[0]); end
        total++; if (busy_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1)
            begin bad++; $display("FAIL rstmid_flags: busy=%b in_ready=%b want 0 1", busy_a[0], in_ready_a[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        d = rnd128();
        drive_accept(0, d, model_inv(d));
        wait_out(0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL rstmid_after_latency: got %0d want 4", lat); end
        total++;
        if (exp_q[0].size() == 0) begin bad++; $display("FAIL rstmid_after_data: no expected entry"); end
        else begin
            e = exp_q[0].pop_front();
            if (out_state_a[0] !== e) begin bad++; $display("FAIL rstmid_after_data: got %h want %h", out_state_a[0], e); end
        end
        @(negedge clk);
    endtask

`ifdef INV_SUB_BYTES_FWD_EN
    task automatic test_fwd();
        int lat;
        logic [127:0] e;
        out_ready = 1'b1;
        fwd = 1'b1;
        drive_accept(0, E1, V1);
        fwd = 1'b0;
        wait_out(0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL fwd_latency: got %0d want 4", lat); end
        total++;
        if (exp_q[0].size() == 0) begin bad++; $display("FAIL fwd_data: no expected entry"); end
        else begin
            e = exp_q[0].pop_front();
            if (out_state_a[0] !== e) begin bad++; $display("FAIL fwd_data: got %h want %h", out_state_a[0], e); end
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_tables();
        test_reset();
        test_basic();
        test_patterns();
        test_backpressure();
        test_sweep();
        test_reset_mid();
`ifdef INV_SUB_BYTES_FWD_EN
        test_fwd();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
